// File: rtl/dpm_ib_prefetch.sv
// Instruction-byte prefetch queue feeding the IRD decoder: fetches aligned longwords, retires 1/2/4 bytes per cycle.
// Optional per-byte parity storage and check enabled by defining IB_PARITY_EN.
module dpm_ib_prefetch #(
    parameter int DEPTH_BYTES = 8
) (
    input  logic        mclk_l,
    input  logic        reset_h,
    input  logic        flush_h,
    input  logic [1:0]  flush_pc_h,
    output logic        mem_req_h,
    input  logic        mem_ack_h,
    input  logic [31:0] mem_data_h,
    input  logic [1:0]  take_h,
`ifdef IB_PARITY_EN
    input  logic [3:0]  mem_par_h,
    output logic        xbuf_perr_h,
`endif
    output logic [15:0] xbuf_h,
    output logic [3:0]  ib_cnt_h,
    output logic        ib_err_h
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = $clog2(DEPTH_BYTES + 1);

    typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;

    req_state_t       state;
    req_state_t       state_nxt;
    logic [7:0]       mem [DEPTH_BYTES];
`ifdef IB_PARITY_EN
    logic             par_mem [DEPTH_BYTES];
`endif
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx1;
    logic [CNT_W-1:0] count;
    logic [1:0]       skip;
    logic             err;
    logic [2:0]       take_n;
    logic [2:0]       wr_n;
    logic             take_ok;
    logic             do_wr;
    logic             room;
    logic [CNT_W-1:0] take_amt;
    logic [CNT_W-1:0] wr_amt;

    function automatic logic [2:0] decode_take(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        take_n   = decode_take(take_h);
        take_ok  = CNT_W'(take_n) <= count;
        do_wr    = mem_req_h && mem_ack_h && !flush_h && !reset_h;
        wr_n     = 3'd4 - {1'b0, skip};
        wr_amt   = do_wr ? CNT_W'(wr_n) : '0;
        take_amt = take_ok ? CNT_W'(take_n) : '0;
        // Request decision uses the registered count, ignoring this cycle's take.
        room     = count <= CNT_W'(DEPTH_BYTES - 4);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REQ_IDLE: if (room) state_nxt = REQ_WAIT;
            REQ_WAIT: if (mem_ack_h) state_nxt = REQ_IDLE;
            default:  state_nxt = REQ_IDLE;
        endcase
        if (flush_h) state_nxt = REQ_IDLE;
    end

    always_ff @(posedge mclk_l) begin
        if (reset_h) state <= REQ_IDLE;
        else         state <= state_nxt;
    end

    assign mem_req_h = (state == REQ_WAIT);

    always_ff @(posedge mclk_l) begin
        if (reset_h || flush_h) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            skip   <= reset_h ? 2'd0 : flush_pc_h;
        end else begin
            if (take_ok) rd_ptr <= rd_ptr + PTR_W'(take_n);
            else         err    <= 1'b1;
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(wr_n);
                skip   <= 2'd0;
            end
            count <= count + wr_amt - take_amt;
        end
    end

    // Byte storage carries no reset; the count masks stale entries.
    always_ff @(posedge mclk_l) begin
        if (do_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(skip)) begin
                    mem[wr_ptr + PTR_W'(i - int'(skip))] <= mem_data_h[8*i +: 8];
`ifdef IB_PARITY_EN
                    par_mem[wr_ptr + PTR_W'(i - int'(skip))] <= mem_par_h[i];
`endif
                end
            end
        end
    end

    assign rd_ptr_nx1 = rd_ptr + PTR_W'(1);

    always_comb begin
        xbuf_h = 16'h0000;
        if (count >= CNT_W'(1)) xbuf_h[7:0]  = mem[rd_ptr];
        if (count >= CNT_W'(2)) xbuf_h[15:8] = mem[rd_ptr_nx1];
    end

`ifdef IB_PARITY_EN
    always_comb begin
        xbuf_perr_h = 1'b0;
        if (count >= CNT_W'(1) && !(^{par_mem[rd_ptr], mem[rd_ptr]}))         xbuf_perr_h = 1'b1;
        if (count >= CNT_W'(2) && !(^{par_mem[rd_ptr_nx1], mem[rd_ptr_nx1]})) xbuf_perr_h = 1'b1;
    end
`endif

    assign ib_cnt_h = 4'(count);
    assign ib_err_h = err;

endmodule

// File: tb/tb_dpm_ib_prefetch.sv
// Randomized self-checking bench for dpm_ib_prefetch against a byte-queue reference model.
// Parity output is checked when IB_PARITY_EN is defined.
module tb_dpm_ib_prefetch;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_h = 1'b1;
    logic        flush_h = 1'b0;
    logic [1:0]  flush_pc_h = 2'd0;
    logic        mem_req_h;
    logic        mem_ack_h = 1'b0;
    logic [31:0] mem_data_h = 32'h0;
    logic [1:0]  take_h = 2'd0;
`ifdef IB_PARITY_EN
    logic [3:0]  mem_par_h = 4'h0;
    logic        xbuf_perr_h;
`endif
    logic [15:0] xbuf_h;
    logic [3:0]  ib_cnt_h;
    logic        ib_err_h;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: byte stream queue, bit 8 marks a byte delivered with bad parity.
    logic [8:0] q[$];
    bit         m_err = 1'b0;
    int         m_skip = 0;
    bit         m_req = 1'b0;

    always #5 clk = ~clk;

    dpm_ib_prefetch #(.DEPTH_BYTES(DEPTH)) dut (
        .mclk_l     (clk),
        .reset_h    (reset_h),
        .flush_h    (flush_h),
        .flush_pc_h (flush_pc_h),
        .mem_req_h  (mem_req_h),
        .mem_ack_h  (mem_ack_h),
        .mem_data_h (mem_data_h),
        .take_h     (take_h),
`ifdef IB_PARITY_EN
        .mem_par_h  (mem_par_h),
        .xbuf_perr_h(xbuf_perr_h),
`endif
        .xbuf_h     (xbuf_h),
        .ib_cnt_h   (ib_cnt_h),
        .ib_err_h   (ib_err_h)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic fl, input logic [1:0] pc, input logic ack,
                              input logic [31:0] data, input logic [1:0] tk, input logic [3:0] bad);
        int n;
        int old_len;
        bit old_req;
        n = (tk == 2'd3) ? 4 : int'(tk);
        if (rst) begin
            q.delete(); m_err = 1'b0; m_skip = 0; m_req = 1'b0;
        end else if (fl) begin
            q.delete(); m_err = 1'b0; m_skip = int'(pc); m_req = 1'b0;
        end else begin
            old_len = q.size();
            old_req = m_req;
            if (n > old_len) m_err = 1'b1;
            else repeat (n) void'(q.pop_front());
            if (old_req && ack) begin
                for (int i = m_skip; i < 4; i++) q.push_back({bad[i], data[8*i +: 8]});
                m_skip = 0;
                m_req = 1'b0;
            end else if (!old_req) begin
                m_req = (old_len + 4 <= DEPTH);
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic fl, input logic [1:0] pc, input logic ack,
                       input logic [31:0] data, input logic [1:0] tk, input logic [3:0] bad);
        logic [15:0] exp_x;
        reset_h = rst; flush_h = fl; flush_pc_h = pc;
        mem_ack_h = ack; mem_data_h = data; take_h = tk;
`ifdef IB_PARITY_EN
        for (int i = 0; i < 4; i++) mem_par_h[i] = ~(^data[8*i +: 8]) ^ bad[i];
`endif
        @(posedge clk);
        model_step(rst, fl, pc, ack, data, tk, bad);
        #1;
        exp_x = 16'h0;
        if (q.size() >= 1) exp_x[7:0]  = q[0][7:0];
        if (q.size() >= 2) exp_x[15:8] = q[1][7:0];
        check_eq("cnt",  32'(ib_cnt_h),  32'(q.size()));
        check_eq("xbuf", 32'(xbuf_h),    32'(exp_x));
        check_eq("req",  32'(mem_req_h), 32'(m_req));
        check_eq("err",  32'(ib_err_h),  32'(m_err));
`ifdef IB_PARITY_EN
        check_eq("perr", 32'(xbuf_perr_h),
                 32'((q.size() >= 1 && q[0][8]) || (q.size() >= 2 && q[1][8])));
`endif
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 2'd0, 4'h0);
    endtask

    initial begin
        logic       r_rst, r_fl, r_ack;
        logic [1:0] r_tk;
        logic [3:0] r_bad;

        cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 2'd0, 4'h0);
        cyc(1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 2'd0, 4'h0);
        check_eq("rst_cnt", 32'(ib_cnt_h), 32'd0);
        check_eq("rst_req", 32'(mem_req_h), 32'd0);

        idle();
        check_eq("first_req", 32'(mem_req_h), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'h4433_2211, 2'd0, 4'h0);
        check_eq("lw1_xbuf", 32'(xbuf_h), 32'h2211);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 2'd2, 4'h0);
        check_eq("take2_xbuf", 32'(xbuf_h), 32'h4433);
        check_eq("take2_cnt", 32'(ib_cnt_h), 32'd2);

        cyc(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 2'd0, 4'h0);
        idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'hDDCC_BBAA, 2'd0, 4'h0);
        check_eq("skip3_xbuf", 32'(xbuf_h), 32'h00DD);
        check_eq("skip3_cnt", 32'(ib_cnt_h), 32'd1);
        idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'h4433_2211, 2'd0, 4'h0);
        check_eq("skip3_fill", 32'(xbuf_h), 32'h11DD);

        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 2'd0, 4'h0);
        idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'h0302_0100, 2'd0, 4'h0);
        idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'h0706_0504, 2'd0, 4'h0);
        idle();
        check_eq("full_cnt", 32'(ib_cnt_h), 32'd8);
        check_eq("full_noreq", 32'(mem_req_h), 32'd0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 2'd3, 4'h0);
        idle();
        check_eq("req_after_take", 32'(mem_req_h), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'h0B0A_0908, 2'd2, 4'h0);
        check_eq("ack_take_cnt", 32'(ib_cnt_h), 32'd6);
        check_eq("ack_take_xbuf", 32'(xbuf_h), 32'h0706);

        cyc(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 2'd0, 4'h0);
        idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'hDDCC_BBAA, 2'd0, 4'h0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 2'd2, 4'h0);
        check_eq("uflow_err", 32'(ib_err_h), 32'd1);
        check_eq("uflow_cnt", 32'(ib_cnt_h), 32'd1);
        idle();
        check_eq("uflow_sticky", 32'(ib_err_h), 32'd1);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 2'd0, 4'h0);
        check_eq("flush_err", 32'(ib_err_h), 32'd0);

        idle();
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 32'h1234_5678, 2'd0, 4'h0);
        check_eq("flush_ack_cnt", 32'(ib_cnt_h), 32'd0);
        check_eq("flush_ack_req", 32'(mem_req_h), 32'd0);
        idle();
        check_eq("flush_ack_rereq", 32'(mem_req_h), 32'd1);

        for (int k = 0; k < 4000; k++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_ack = 1'($urandom_range(0, 1));
            r_tk  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            r_bad = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cyc(r_rst, r_fl, 2'($urandom_range(0, 3)), r_ack, $urandom, r_tk, r_bad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
